// File: rtl/uart_tx_arbiter_if.sv
// Byte-stream requesters on one side, shared UART transmitter byte port on the other.
// slave is the arbiter's view; master is the view of whatever drives the requesters and the transmitter.
interface uart_tx_arbiter_if #(
   parameter int NUM_REQ = 4
);
   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ-1:0][7:0]  req_data;
   logic [NUM_REQ-1:0]       req_last;
   logic [NUM_REQ-1:0]       req_ready;
   logic [7:0]               tx_data;
   logic                     tx_valid;
   logic                     tx_ready;
   logic [NUM_REQ-1:0]       grant;
   logic                     busy;

   modport master (
      output req_valid, req_data, req_last, tx_ready,
      input  req_ready, tx_data, tx_valid, grant, busy
   );

   modport slave (
      input  req_valid, req_data, req_last, tx_ready,
      output req_ready, tx_data, tx_valid, grant, busy
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one UART transmitter byte port.
// Handoff to the transmitter is edge based: it accepts a byte by dropping tx_ready and is done when tx_ready rises.
module uart_tx_arbiter #(
   parameter int         NUM_REQ     = 4,
   parameter bit         HEADER_EN   = 1'b1,
   parameter logic [7:0] HEADER_BASE = 8'hA0,
   parameter int         MAX_BURST   = 16
) (
   input logic              clk,
   input logic              rst,
   uart_tx_arbiter_if.slave bus
);
   localparam int IW = $clog2(NUM_REQ);

   typedef enum logic [2:0] {IDLE, HDR, LOAD, ISSUE, WAIT_DONE} state_t;

   state_t             state;
   logic [IW-1:0]      rr_ptr;
   logic [IW-1:0]      idx;
   logic [NUM_REQ-1:0] grant_r;
   logic [7:0]         tx_data_r;
   logic               tx_valid_r;
   logic [7:0]         burst_cnt;
   logic               hdr_flag;
   logic               last_flag;

   logic [IW-1:0]      pick;
   logic [IW-1:0]      cand;
   logic               found;

   // First valid requester searching upward from rr_ptr+1 with wrap.
   always_comb begin
      pick  = '0;
      cand  = '0;
      found = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = IW'((32'(rr_ptr) + 32'(k)) % NUM_REQ);
         if (!found && bus.req_valid[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   assign bus.req_ready = (state == LOAD) ? grant_r : '0;
   assign bus.grant     = grant_r;
   assign bus.tx_data   = tx_data_r;
   assign bus.tx_valid  = tx_valid_r;
   assign bus.busy      = (state != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         rr_ptr     <= IW'(NUM_REQ - 1);
         idx        <= '0;
         grant_r    <= '0;
         tx_data_r  <= 8'h00;
         tx_valid_r <= 1'b0;
         burst_cnt  <= 8'd0;
         hdr_flag   <= 1'b0;
         last_flag  <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.tx_ready && found) begin
                  idx       <= pick;
                  rr_ptr    <= pick;
                  grant_r   <= NUM_REQ'(1) << pick;
                  burst_cnt <= 8'd0;
                  state     <= HEADER_EN ? HDR : LOAD;
               end
            end
            HDR: begin
               tx_data_r  <= HEADER_BASE | 8'(idx);
               hdr_flag   <= 1'b1;
               tx_valid_r <= 1'b1;
               state      <= ISSUE;
            end
            // Grant is held even if the owner stalls: packets must complete.
            LOAD: begin
               if (bus.req_valid[idx]) begin
                  tx_data_r  <= bus.req_data[idx];
                  last_flag  <= bus.req_last[idx];
                  if (burst_cnt != 8'hFF) burst_cnt <= burst_cnt + 8'd1;
                  hdr_flag   <= 1'b0;
                  tx_valid_r <= 1'b1;
                  state      <= ISSUE;
               end
            end
            ISSUE: begin
               if (!bus.tx_ready) begin
                  tx_valid_r <= 1'b0;
                  state      <= WAIT_DONE;
               end
            end
            WAIT_DONE: begin
               if (bus.tx_ready) begin
                  if (hdr_flag) begin
                     state <= LOAD;
                  end else if (last_flag || burst_cnt == 8'(MAX_BURST)) begin
                     grant_r <= '0;
                     state   <= IDLE;
                  end else begin
                     state <= LOAD;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench: dut_a (header on, MAX_BURST=4) with modelled requesters and transmitter,
// dut_b (header off) driven directly for the headerless latency case.
module tb_uart_tx_arbiter;
   localparam int N    = 4;
   localparam int BUSY = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   uart_tx_arbiter_if #(.NUM_REQ(N)) bus_a();
   uart_tx_arbiter_if #(.NUM_REQ(N)) bus_b();

   uart_tx_arbiter #(.NUM_REQ(N), .HEADER_EN(1'b1), .HEADER_BASE(8'hA0), .MAX_BURST(4)) dut_a (
      .clk(clk), .rst(rst), .bus(bus_a)
   );
   uart_tx_arbiter #(.NUM_REQ(N), .HEADER_EN(1'b0), .HEADER_BASE(8'hA0), .MAX_BURST(16)) dut_b (
      .clk(clk), .rst(rst), .bus(bus_b)
   );

   typedef struct packed {
      logic [7:0]   d;
      logic [N-1:0] g;
   } exp_t;

   exp_t       exp_q[$];
   logic [8:0] rq[N][$];
   int         total = 0;
   int         bad   = 0;
   int         bcnt  = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, want);
      end
   endtask

   task automatic send(input int r, input logic [7:0] d, input logic last);
      rq[r].push_back({last, d});
   endtask

   task automatic exp_push(input logic [7:0] d, input int r);
      exp_t e;
      e.d = d;
      e.g = N'(1) << r;
      exp_q.push_back(e);
   endtask

   task automatic flush();
      exp_q.delete();
      for (int i = 0; i < N; i++) rq[i].delete();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      flush();
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic drain(input string tag);
      int n;
      int left;
      n = 0;
      while ((exp_q.size() != 0 || bus_a.busy) && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_timeout"}, 32'(n >= 500), 32'd0);
      left = 0;
      for (int i = 0; i < N; i++) left += rq[i].size();
      chk({tag, "_req_left"}, 32'(left), 32'd0);
      chk({tag, "_grant_idle"}, 32'(bus_a.grant), 32'd0);
      chk({tag, "_busy_idle"}, 32'(bus_a.busy), 32'd0);
   endtask

   // Transmitter model: accepts on tx_valid, stays busy BUSY cycles.
   initial begin
      exp_t e;
      bus_a.tx_ready = 1'b1;
      forever begin
         @(negedge clk);
         if (rst) begin
            bus_a.tx_ready = 1'b1;
            bcnt = 0;
         end else begin
            if (bus_a.busy) chk("rdy_outside_grant", 32'(bus_a.req_ready & ~bus_a.grant), 32'd0);
            if (bcnt > 0) begin
               if (bcnt == BUSY) chk("txv_drop", 32'(bus_a.tx_valid), 32'd0);
               bcnt--;
               if (bcnt == 0) bus_a.tx_ready = 1'b1;
            end else if (bus_a.tx_valid && bus_a.tx_ready) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_byte", 32'(bus_a.tx_data), 32'hFFFF);
               end else begin
                  e = exp_q.pop_front();
                  chk("tx_data", 32'(bus_a.tx_data), 32'(e.d));
                  chk("tx_grant", 32'(bus_a.grant), 32'(e.g));
               end
               bus_a.tx_ready = 1'b0;
               bcnt = BUSY;
            end
         end
      end
   end

   // Requester model: presents the head of each queue, pops on consume.
   initial begin
      logic [N-1:0] cons;
      bus_a.req_valid = '0;
      bus_a.req_last  = '0;
      bus_a.req_data  = '0;
      forever begin
         @(negedge clk);
         cons = rst ? '0 : (bus_a.req_valid & bus_a.req_ready);
         @(posedge clk);
         #1;
         for (int i = 0; i < N; i++) begin
            if (cons[i] && rq[i].size() > 0) void'(rq[i].pop_front());
            if (!rst && rq[i].size() > 0) begin
               bus_a.req_valid[i] = 1'b1;
               bus_a.req_data[i]  = rq[i][0][7:0];
               bus_a.req_last[i]  = rq[i][0][8];
            end else begin
               bus_a.req_valid[i] = 1'b0;
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not end");
      $fatal(1);
   end

   initial begin
      int n;
      bus_b.req_valid = '0;
      bus_b.req_last  = '0;
      bus_b.req_data  = '0;
      bus_b.tx_ready  = 1'b1;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_tx_valid", 32'(bus_a.tx_valid), 32'd0);
      chk("rst_tx_data", 32'(bus_a.tx_data), 32'd0);
      chk("rst_grant", 32'(bus_a.grant), 32'd0);
      chk("rst_req_ready", 32'(bus_a.req_ready), 32'd0);
      chk("rst_busy", 32'(bus_a.busy), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Headerless: IDLE -> LOAD -> ISSUE, tx_valid two cycles after req_valid.
      @(posedge clk);
      #1;
      bus_b.req_valid[0] = 1'b1;
      bus_b.req_data[0]  = 8'hC3;
      bus_b.req_last[0]  = 1'b1;
      @(negedge clk);
      chk("b_txv_c0", 32'(bus_b.tx_valid), 32'd0);
      @(negedge clk);
      chk("b_txv_c1", 32'(bus_b.tx_valid), 32'd0);
      chk("b_req_ready", 32'(bus_b.req_ready), 32'h1);
      chk("b_grant", 32'(bus_b.grant), 32'h1);
      @(posedge clk);
      #1;
      bus_b.req_valid = '0;
      @(negedge clk);
      chk("b_txv_c2", 32'(bus_b.tx_valid), 32'd1);
      chk("b_tx_data", 32'(bus_b.tx_data), 32'hC3);
      bus_b.tx_ready = 1'b0;
      @(negedge clk);
      chk("b_txv_drop", 32'(bus_b.tx_valid), 32'd0);
      chk("b_busy", 32'(bus_b.busy), 32'd1);
      bus_b.tx_ready = 1'b1;
      @(negedge clk);
      chk("b_grant_idle", 32'(bus_b.grant), 32'd0);
      chk("b_busy_idle", 32'(bus_b.busy), 32'd0);

      // Single 1-byte packet from requester 2, header latency from arbitration.
      do_reset();
      send(2, 8'h55, 1'b1);
      exp_push(8'hA2, 2);
      exp_push(8'h55, 2);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus_a.tx_valid && n < 20);
      chk("hdr_latency", 32'(n), 32'd3);
      drain("t1");

      // Two requesters pending from reset: requester 0 first, then 1.
      do_reset();
      send(0, 8'h11, 1'b0); send(0, 8'h12, 1'b1);
      send(1, 8'h21, 1'b0); send(1, 8'h22, 1'b1);
      exp_push(8'hA0, 0); exp_push(8'h11, 0); exp_push(8'h12, 0);
      exp_push(8'hA1, 1); exp_push(8'h21, 1); exp_push(8'h22, 1);
      drain("t2");

      // Packet lock: requester 0 shows up mid-packet of requester 3.
      do_reset();
      send(3, 8'h31, 1'b0); send(3, 8'h32, 1'b0); send(3, 8'h33, 1'b1);
      exp_push(8'hA3, 3); exp_push(8'h31, 3); exp_push(8'h32, 3); exp_push(8'h33, 3);
      n = 0;
      while (bus_a.grant != 4'b1000 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("t3_grant_wait", 32'(n >= 50), 32'd0);
      send(0, 8'h01, 1'b1);
      exp_push(8'hA0, 0); exp_push(8'h01, 0);
      drain("t3");

      // Forced release after MAX_BURST=4 bytes, requester 2 served in between.
      do_reset();
      for (int i = 0; i < 6; i++) send(1, 8'h81 + 8'(i), 1'(i == 5));
      send(2, 8'h91, 1'b1);
      exp_push(8'hA1, 1);
      for (int i = 0; i < 4; i++) exp_push(8'h81 + 8'(i), 1);
      exp_push(8'hA2, 2); exp_push(8'h91, 2);
      exp_push(8'hA1, 1); exp_push(8'h85, 1); exp_push(8'h86, 1);
      drain("t4");

      // Reset while ISSUE is presenting a byte.
      do_reset();
      send(0, 8'h61, 1'b0); send(0, 8'h62, 1'b1);
      exp_push(8'hA0, 0);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus_a.tx_valid && n < 20);
      chk("t6_issue_wait", 32'(n >= 20), 32'd0);
      #2;
      rst = 1'b1;
      #1;
      chk("t6_rst_txv", 32'(bus_a.tx_valid), 32'd0);
      chk("t6_rst_grant", 32'(bus_a.grant), 32'd0);
      chk("t6_rst_busy", 32'(bus_a.busy), 32'd0);
      flush();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      send(1, 8'h71, 1'b1);
      send(0, 8'h72, 1'b1);
      exp_push(8'hA0, 0); exp_push(8'h72, 0);
      exp_push(8'hA1, 1); exp_push(8'h71, 1);
      drain("t6");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin, packet-locked arbiter that shares one UART transmitter byte interface (tx_data/tx_valid/tx_ready) between NUM_REQ byte-stream requesters.
- Optionally prefixes each granted burst with a channel-ID header byte.
- Sits between on-chip byte sources (debug, status, log streams) and the UART transmitter. The transmitter samples tx_valid only on its baud tick, so handoff is edge-based on tx_ready rather than a single-cycle valid/ready handshake.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- HEADER_EN, 1, 1 = send header byte (HEADER_BASE | grant index) before each burst.
- HEADER_BASE, 8'hA0, header byte base; the low 3 bits must be zero.
- MAX_BURST, 16, maximum payload bytes per grant before forced release; legal range 1..255.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- req_valid  in  NUM_REQ  per-requester byte available
- req_data  in  NUM_REQ*8  per-requester byte; requester i uses bits [8i+7:8i]
- req_last  in  NUM_REQ  byte is the last of its packet
- req_ready  out  NUM_REQ  byte consumed when req_valid & req_ready
- tx_data  out  8  byte to transmitter, registered
- tx_valid  out  1  byte request to transmitter, registered
- tx_ready  in  1  transmitter idle (high) / busy (low)
- grant  out  NUM_REQ  one-hot current owner; all-zero when idle
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset values:
  - tx_valid=0, tx_data=8'h00, grant=0, req_ready=0, busy=0.
  - rr_ptr=NUM_REQ-1, so requester 0 wins the first arbitration.
  - burst_cnt=0; state=IDLE.
- Reset mid-operation returns to IDLE immediately. Any in-flight byte is abandoned; the transmitter is reset by the same rst.
- req_ready is combinational: req_ready[i] = (state==LOAD) & grant[i]. A consume occurs on any cycle where this is high and req_valid[i] is high.
- FSM states:
  - IDLE: when tx_ready==1 and any req_valid is high, select the first set req_valid searching from (rr_ptr+1) mod NUM_REQ upward with wrap. Set grant to that one-hot index, set rr_ptr to the index, clear burst_cnt. Next state is HDR if HEADER_EN, else LOAD. If tx_ready==0, stay in IDLE.
  - HDR: tx_data <= HEADER_BASE | index; hdr_flag <= 1; go to ISSUE.
  - LOAD: wait for req_valid[idx].
    - On consume: tx_data <= byte; last_flag <= req_last[idx]; burst_cnt <= burst_cnt+1; hdr_flag <= 0; go to ISSUE.
    - If the requester drops valid, wait indefinitely with the grant held. Requesters must complete packets.
  - ISSUE: tx_valid=1, with tx_data held stable.
    - When tx_ready is sampled 0 (transmitter accepted), tx_valid <= 0 and go to WAIT_DONE.
    - Entry to ISSUE only ever follows an observed tx_ready==1.
  - WAIT_DONE: wait for tx_ready==1, then:
    - if hdr_flag → LOAD;
    - else if last_flag or burst_cnt==MAX_BURST → IDLE, grant <= 0;
    - else → LOAD.
- Latency, HEADER_EN=1, from the IDLE arbitration cycle:
  - header tx_valid rises 2 cycles later (IDLE→HDR→ISSUE registered);
  - first payload consume occurs 1 cycle after the WAIT_DONE exit.
- Forced release at MAX_BURST:
  - the grant ends mid-packet and rr_ptr is unchanged, so other requesters are served first;
  - the same requester's next grant re-sends the header and continues with its next byte.
- Simultaneous events:
  - requests arriving while not in IDLE are ignored until the next IDLE;
  - a requester re-requesting at release competes normally; with others pending, rr order makes it lowest priority.
- burst_cnt is 8-bit, saturating compare only; it is never allowed to wrap.

Test Plan:
- HEADER_EN=1, requester 2 sends 1-byte packet 8'h55 with last=1 → tx_data sequence A2, 55; two tx_valid pulses, each dropping the cycle after tx_ready falls; grant=4'b0100 throughout; IDLE with grant=0 after the final tx_ready rise.
- Requesters 0 and 1 both hold 2-byte packets (11,12 / 21,22) from reset → bytes A0,11,12,A1,21,22; req_ready[1] never high during requester 0's grant.
- Packet lock: requester 3 packet of 3 bytes; requester 0 asserts valid mid-packet → requester 0 not granted until after requester 3's last byte completes.
- MAX_BURST=4, requester 1 streams 6 bytes with last on the 6th, requester 2 pending 1 byte → A1,b1..b4,A2,c1,A1,b5,b6.
- HEADER_EN=0, single requester 0, byte 8'hC3, last=1 → only C3 sent; tx_valid rises 2 cycles after req_valid (IDLE→LOAD→ISSUE).
- rst asserted in ISSUE during a burst → same-cycle (asynchronous) tx_valid=0, grant=0, busy=0; after release, requester 0 is the first winner again.
